fetch_sequencer: RTL and testbench

Instruction-fetch controller for the single-cycle RISC-V core. It owns the program counter and drives the address of the combinational instruction memory. It registers each fetched word into an output slot with a valid/ready handshake toward decode. It accepts branch/jump redirects from execute and stops cleanly at the end of the loaded program, or on a misaligned target.

---
 rtl/fetch_sequencer.sv | 105 ++++++++++
 tb/tb_fetch_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, reads the combinational imem, registers words into a decode slot.
// Latency: a word is valid one edge after its PC is presented; an aligned redirect costs exactly one bubble.
// Backpressure: while out_valid && !out_ready, the slot, pc and imem_addr hold; redirects still flush the slot.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          PROG_WORDS = 9,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_inst,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [31:0]      out_pc,
  output logic             halted,
  output logic             error,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_END   = 2'd1;
  localparam logic [1:0] ST_ERROR = 2'd2;

  // One past the last fetchable byte address, kept 33 bits wide so the bound cannot wrap.
  localparam logic [32:0] PC_LIMIT = {1'b0, RESET_PC} + 33'(4 * PROG_WORDS);

  logic [31:0] pc;
  logic [1:0]  state;
  logic        in_range;
  logic        slot_free;
  logic        fire;
  logic        tgt_misaligned;

  assign in_range       = (pc >= RESET_PC) && ({1'b0, pc} < PC_LIMIT);
  assign slot_free      = !out_valid || out_ready;
  assign fire           = out_valid && out_ready;
  assign tgt_misaligned = (redirect_target[1:0] != 2'b00);

  // The memory address always comes straight from the pc register; redirects only act through pc.
  assign imem_addr = pc;
  assign halted    = (state == ST_END) && !out_valid;
  assign error     = (state == ST_ERROR);

  // Completed handshakes, counted in every state; wraps naturally at CNT_W bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= '0;
    end else if (fire) begin
      fetch_count <= fetch_count + 1'b1;
    end
  end

  // PC, output slot and control state: redirect beats fetch, fetch beats end-of-program.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC;
      out_valid <= 1'b0;
      out_inst  <= 32'h0;
      out_pc    <= 32'h0;
      state     <= ST_FETCH;
    end else begin
      case (state)
        ST_FETCH: begin
          if (redirect_valid && tgt_misaligned) begin
            state     <= ST_ERROR;
            out_valid <= 1'b0;
          end else if (redirect_valid) begin
            // Slot is flushed even if decode takes it this edge; the handshake is still counted.
            pc        <= redirect_target;
            out_valid <= 1'b0;
          end else if (slot_free && in_range) begin
            out_inst  <= imem_inst;
            out_pc    <= pc;
            out_valid <= 1'b1;
            pc        <= pc + 32'd4;
          end else if (slot_free) begin
            // Ran off the end of the program (or redirected outside it): drain and stop.
            out_valid <= 1'b0;
            state     <= ST_END;
          end
        end
        ST_END: begin
          if (redirect_valid && tgt_misaligned) begin
            state <= ST_ERROR;
          end else if (redirect_valid) begin
            pc    <= redirect_target;
            state <= ST_FETCH;
          end
        end
        ST_ERROR: begin
          out_valid <= 1'b0;
        end
        default: begin
          state     <= ST_ERROR;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios followed by randomized redirects, backpressure and resets.
// Every edge is checked against a register-level model of the fetch rules working on the program array.
// Inputs change #1 after the rising edge; outputs are sampled at that same point.
module tb_fetch_sequencer;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          PROG_WORDS = 9;
  localparam int          CNT_W      = 16;

  localparam int M_FETCH = 0;
  localparam int M_END   = 1;
  localparam int M_ERROR = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_inst;
  logic             redirect_valid;
  logic [31:0]      redirect_target;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_inst;
  logic [31:0]      out_pc;
  logic             halted;
  logic             error;
  logic [CNT_W-1:0] fetch_count;

  logic [31:0] prog [PROG_WORDS];
  logic [31:0] tb_off;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [31:0]      m_pc;
  logic             m_vld;
  logic [31:0]      m_opc;
  logic [31:0]      m_inst;
  int               m_mode;
  logic [CNT_W-1:0] m_cnt;

  // Random stimulus scratch
  logic        r_rv;
  logic        r_rdy;
  logic        r_rst;
  logic [31:0] r_rt;

  fetch_sequencer #(
    .RESET_PC  (RESET_PC),
    .PROG_WORDS(PROG_WORDS),
    .CNT_W     (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .halted         (halted),
    .error          (error),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  // Combinational instruction memory; addresses outside the program return a recognisable junk pattern.
  assign tb_off = imem_addr - RESET_PC;
  always_comb begin
    imem_inst = 32'hDEAD_0000 ^ imem_addr;
    if (tb_off < 32'(4 * PROG_WORDS)) imem_inst = prog[int'(tb_off >> 2)];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic model_in_range(input logic [31:0] a);
    return (a >= RESET_PC) && ((a - RESET_PC) < 32'(4 * PROG_WORDS));
  endfunction

  // Apply one cycle of inputs, advance model by the fetch rules, compare every output.
  task automatic step(input logic rv, input logic [31:0] rt, input logic rdy, input logic rst);
    redirect_valid  = rv;
    redirect_target = rt;
    out_ready       = rdy;
    reset           = rst;
    @(posedge clk);
    if (rst) begin
      m_pc = RESET_PC; m_vld = 1'b0; m_opc = 32'h0; m_inst = 32'h0;
      m_mode = M_FETCH; m_cnt = '0;
    end else begin
      if (m_vld && rdy) m_cnt = m_cnt + 1'b1;
      if (m_mode == M_FETCH) begin
        if (rv && rt[1:0] != 2'b00) begin
          m_mode = M_ERROR; m_vld = 1'b0;
        end else if (rv) begin
          m_pc = rt; m_vld = 1'b0;
        end else if (!m_vld || rdy) begin
          if (model_in_range(m_pc)) begin
            m_opc  = m_pc;
            m_inst = prog[int'((m_pc - RESET_PC) >> 2)];
            m_vld  = 1'b1;
            m_pc   = m_pc + 32'd4;
          end else begin
            m_vld  = 1'b0;
            m_mode = M_END;
          end
        end
      end else if (m_mode == M_END) begin
        if (rv && rt[1:0] != 2'b00) m_mode = M_ERROR;
        else if (rv) begin
          m_pc = rt; m_mode = M_FETCH;
        end
      end
    end
    #1;
    check("out_valid",   32'(out_valid),   32'(m_vld));
    check("imem_addr",   imem_addr,        m_pc);
    check("out_pc",      out_pc,           m_opc);
    check("out_inst",    out_inst,         m_inst);
    check("halted",      32'(halted),      32'(m_mode == M_END && !m_vld));
    check("error",       32'(error),       32'(m_mode == M_ERROR));
    check("fetch_count", 32'(fetch_count), 32'(m_cnt));
  endtask

  initial begin
    prog[0] = 32'h0010_0293; prog[1] = 32'h0030_0313; prog[2] = 32'h0062_B223;
    prog[3] = 32'h0002_A383; prog[4] = 32'h0073_0433; prog[5] = 32'h4064_0533;
    prog[6] = 32'h00A0_0593; prog[7] = 32'h00B5_0633; prog[8] = 32'h4053_83B3;
    m_pc = 32'h0; m_vld = 1'b0; m_opc = 32'h0; m_inst = 32'h0; m_mode = M_FETCH; m_cnt = '0;
    redirect_valid = 1'b0; redirect_target = 32'h0; out_ready = 1'b0; reset = 1'b1;

    // Reset state
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'h10, 1'b1, 1'b1);
    check("rst_out_pc", out_pc, 32'h0);

    // Straight-line run to the end of the program
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    check("run_count", 32'(fetch_count), 32'd9);
    check("run_halted", 32'(halted), 32'd1);

    // Redirect while halted restarts at 0 after one bubble
    step(1'b1, 32'h0, 1'b1, 1'b0);
    check("end_redir_halted", 32'(halted), 32'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("end_redir_pc", out_pc, 32'h0);

    // Backpressure at out_pc 0x08
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
    check("bp_inst", out_inst, 32'h0062_B223);
    check("bp_addr", imem_addr, 32'h0000_000C);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("bp_next", out_pc, 32'h0000_000C);

    // Branch at out_pc 0x1C to 0x20, handshake on the same edge still counts
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    check("br_at", out_pc, 32'h0000_001C);
    step(1'b1, 32'h20, 1'b1, 1'b0);
    check("br_bubble", 32'(out_valid), 32'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("br_inst", out_inst, 32'h4053_83B3);

    // Misaligned redirect is sticky until reset
    step(1'b1, 32'h0E, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'(i & 1), 32'h4, 1'b1, 1'b0);
    check("err_sticky", 32'(error), 32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("err_restart", out_pc, 32'h0);

    // Reset together with redirect and handshake
    step(1'b1, 32'h10, 1'b1, 1'b1);
    check("rst_simul_count", 32'(fetch_count), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r_rst = ($urandom_range(0, 199) == 0);
      r_rv  = ($urandom_range(0, 9) == 0);
      r_rt  = 32'($urandom_range(0, 12)) << 2;
      if ($urandom_range(0, 19) == 0) r_rt = r_rt | 32'($urandom_range(1, 3));
      r_rdy = ($urandom_range(0, 9) < 7);
      step(r_rv, r_rt, r_rdy, r_rst);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
